// File: rtl/sram_axi_rd_arb.sv
// Read arbiter between the instruction and data SRAM-style ports onto one AXI read channel.
// One AR is in flight on the bus at a time. Data is preferred over inst when both can issue.
// R beats are routed back by rid[0], and each requester's outstanding reads are counted.
module sram_axi_rd_arb #(
  parameter int unsigned OUTS_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic        busy,
  output logic        err_unexp
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;

  ar_state_t           state_q, state_d;
  logic [CNT_W-1:0]    inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0]    data_cnt_q, data_cnt_d;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [SIZE_W-1:0]   ar_size_q;
  logic [ID_W-1:0]     ar_id_q;
  logic                err_q;

  logic inst_elig, data_elig;
  logic inst_grant, data_grant;
  logic r_fire, inst_beat, data_beat;
  logic inst_dec, data_dec;
  logic rid_unused;

  // Requester eligibility: a pending request with room left in its outstanding budget
  assign data_elig = data_req && (data_cnt_q < CNT_W'(OUTS_MAX));
  assign inst_elig = inst_req && (inst_cnt_q < CNT_W'(OUTS_MAX));

  // R channel is always accepted outside reset; the beat is routed by rid[0]
  assign rready     = resetn;
  assign r_fire     = rvalid && rready;
  assign inst_beat  = r_fire && !rid[0];
  assign data_beat  = r_fire &&  rid[0];
  assign rid_unused = ^rid[3:1];

  // Decrement only when something is outstanding; a stray beat never wraps the counter
  assign inst_dec = inst_beat && (inst_cnt_q != '0);
  assign data_dec = data_beat && (data_cnt_q != '0);

  // AR FSM next state and grant decode
  always_comb begin
    state_d    = state_q;
    inst_grant = 1'b0;
    data_grant = 1'b0;
    case (state_q)
      AR_IDLE: begin
        if (resetn) begin
          if (data_elig) begin
            data_grant = 1'b1;
            state_d    = AR_SEND;
          end else if (inst_elig) begin
            inst_grant = 1'b1;
            state_d    = AR_SEND;
          end
        end
      end
      AR_SEND: begin
        if (arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  // Outstanding-read counters: a grant and a beat in the same cycle cancel out
  always_comb begin
    inst_cnt_d = inst_cnt_q;
    data_cnt_d = data_cnt_q;
    case ({inst_grant, inst_dec})
      2'b10:   inst_cnt_d = inst_cnt_q + CNT_W'(1);
      2'b01:   inst_cnt_d = inst_cnt_q - CNT_W'(1);
      default: inst_cnt_d = inst_cnt_q;
    endcase
    case ({data_grant, data_dec})
      2'b10:   data_cnt_d = data_cnt_q + CNT_W'(1);
      2'b01:   data_cnt_d = data_cnt_q - CNT_W'(1);
      default: data_cnt_d = data_cnt_q;
    endcase
  end

  // State, counters, latched AR fields and sticky error register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= AR_IDLE;
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      ar_id_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      if (data_grant) begin
        ar_addr_q <= data_addr;
        ar_size_q <= {1'b0, data_size};
        ar_id_q   <= ID_W'(1);
      end else if (inst_grant) begin
        ar_addr_q <= inst_addr;
        ar_size_q <= {1'b0, inst_size};
        ar_id_q   <= ID_W'(0);
      end
      if ((inst_beat && (inst_cnt_q == '0)) || (data_beat && (data_cnt_q == '0)))
        err_q <= 1'b1;
    end
  end

  assign inst_addr_ok = inst_grant;
  assign data_addr_ok = data_grant;
  assign inst_data_ok = inst_beat;
  assign data_data_ok = data_beat;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arvalid   = resetn && (state_q == AR_SEND);
  assign araddr    = ar_addr_q;
  assign arsize    = ar_size_q;
  assign arid      = ar_id_q;
  assign arlen     = 8'd0;
  assign busy      = (state_q == AR_SEND) || (inst_cnt_q != '0) || (data_cnt_q != '0);
  assign err_unexp = err_q;

endmodule

// File: tb/tb_sram_axi_rd_arb.sv
// Directed bench for sram_axi_rd_arb: a vector table plus hand-written multi-cycle sequences.
module tb_sram_axi_rd_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic [1:0]  inst_size, data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready, busy, err_unexp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_axi_rd_arb #(.OUTS_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .busy(busy), .err_unexp(err_unexp)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        arrdy;
    logic        rv;
    logic [3:0]  rd_id;
    logic [31:0] rd;
    logic        e_iok;
    logic        e_dok;
    logic        e_arv;
    logic [31:0] e_araddr;
    logic [3:0]  e_arid;
    logic [2:0]  e_arsize;
    logic        e_idok;
    logic        e_ddok;
    logic        e_busy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic ireq, logic [31:0] iaddr, logic dreq, logic [31:0] daddr,
                              logic arrdy, logic rv, logic [3:0] rd_id, logic [31:0] rd,
                              logic e_iok, logic e_dok, logic e_arv, logic [31:0] e_araddr,
                              logic [3:0] e_arid, logic [2:0] e_arsize,
                              logic e_idok, logic e_ddok, logic e_busy);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
    v.arrdy = arrdy; v.rv = rv; v.rd_id = rd_id; v.rd = rd;
    v.e_iok = e_iok; v.e_dok = e_dok; v.e_arv = e_arv; v.e_araddr = e_araddr;
    v.e_arid = e_arid; v.e_arsize = e_arsize;
    v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic [31:0] daddr, input logic arrdy, input logic rv,
                       input logic [3:0] rd_id, input logic [31:0] rd);
    @(negedge clk);
    inst_req = ireq; inst_addr = iaddr; data_req = dreq; data_addr = daddr;
    arready = arrdy; rvalid = rv; rid = rd_id; rdata = rd;
    #2;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    // cycle table: basic read, data-over-inst priority, held AR, routed responses
    vecs[0]  = mk(1, 32'h1C000000, 0, 32'h0,   1, 0, 4'd0, 32'h0,        1, 0, 0, 32'h0,        4'd0, 3'd0, 0, 0, 0);
    vecs[1]  = mk(0, 32'h0,        0, 32'h0,   1, 0, 4'd0, 32'h0,        0, 0, 1, 32'h1C000000, 4'd0, 3'd2, 0, 0, 1);
    vecs[2]  = mk(0, 32'h0,        0, 32'h0,   0, 1, 4'd0, 32'h12345678, 0, 0, 0, 32'h0,        4'd0, 3'd0, 1, 0, 1);
    vecs[3]  = mk(0, 32'h0,        0, 32'h0,   0, 0, 4'd0, 32'h0,        0, 0, 0, 32'h0,        4'd0, 3'd0, 0, 0, 0);
    vecs[4]  = mk(1, 32'h100,      1, 32'h200, 0, 0, 4'd0, 32'h0,        0, 1, 0, 32'h0,        4'd0, 3'd0, 0, 0, 0);
    vecs[5]  = mk(1, 32'h100,      1, 32'h200, 1, 0, 4'd0, 32'h0,        0, 0, 1, 32'h200,      4'd1, 3'd1, 0, 0, 1);
    vecs[6]  = mk(1, 32'h100,      0, 32'h0,   0, 0, 4'd0, 32'h0,        1, 0, 0, 32'h0,        4'd0, 3'd0, 0, 0, 1);
    for (int i = 7; i <= 11; i++)
      vecs[i] = mk(1, 32'h300,     1, 32'h400, 0, 0, 4'd0, 32'h0,        0, 0, 1, 32'h100,      4'd0, 3'd2, 0, 0, 1);
    vecs[12] = mk(0, 32'h0,        0, 32'h0,   1, 0, 4'd0, 32'h0,        0, 0, 1, 32'h100,      4'd0, 3'd2, 0, 0, 1);
    vecs[13] = mk(0, 32'h0,        0, 32'h0,   0, 1, 4'd1, 32'hAAAA5555, 0, 0, 0, 32'h0,        4'd0, 3'd0, 0, 1, 1);
    vecs[14] = mk(0, 32'h0,        0, 32'h0,   0, 1, 4'd0, 32'h0BADF00D, 0, 0, 0, 32'h0,        4'd0, 3'd0, 1, 0, 1);
    vecs[15] = mk(0, 32'h0,        0, 32'h0,   0, 0, 4'd0, 32'h0,        0, 0, 0, 32'h0,        4'd0, 3'd0, 0, 0, 0);

    resetn = 1'b0; inst_size = 2'd2; data_size = 2'd1;
    inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0;

    // reset: nothing is granted, AR/R handshakes held off
    drive(1'b1, 32'h55, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 32'h0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    inst_req = 1'b0; rvalid = 1'b0;
    #2;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_err", 32'(err_unexp), 32'd0);
    chk("post_rst_rready", 32'(rready), 32'd1);
    chk("arlen", 32'(arlen), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].daddr,
            vecs[i].arrdy, vecs[i].rv, vecs[i].rd_id, vecs[i].rd);
      chk($sformatf("v%0d_inst_addr_ok", i), 32'(inst_addr_ok), 32'(vecs[i].e_iok));
      chk($sformatf("v%0d_data_addr_ok", i), 32'(data_addr_ok), 32'(vecs[i].e_dok));
      chk($sformatf("v%0d_arvalid", i), 32'(arvalid), 32'(vecs[i].e_arv));
      chk($sformatf("v%0d_inst_data_ok", i), 32'(inst_data_ok), 32'(vecs[i].e_idok));
      chk($sformatf("v%0d_data_data_ok", i), 32'(data_data_ok), 32'(vecs[i].e_ddok));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_arv) begin
        chk($sformatf("v%0d_araddr", i), araddr, vecs[i].e_araddr);
        chk($sformatf("v%0d_arid", i), 32'(arid), 32'(vecs[i].e_arid));
        chk($sformatf("v%0d_arsize", i), 32'(arsize), 32'(vecs[i].e_arsize));
      end
      if (vecs[i].e_idok) chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].rd);
      if (vecs[i].e_ddok) chk($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].rd);
    end
    chk("table_err", 32'(err_unexp), 32'd0);

    // outstanding limit: four inst reads fill the budget
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1000 + 32'(k * 4), 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
      chk($sformatf("fill%0d_inst_addr_ok", k), 32'(inst_addr_ok), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
      chk($sformatf("fill%0d_arvalid", k), 32'(arvalid), 32'd1);
      chk($sformatf("fill%0d_araddr", k), araddr, 32'h1000 + 32'(k * 4));
    end
    drive(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
    chk("full_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    drive(1'b1, 32'h2000, 1'b1, 32'h3000, 1'b1, 1'b0, 4'd0, 32'h0);
    chk("full_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("full_inst_addr_ok2", 32'(inst_addr_ok), 32'd0);
    drive(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 32'hC0DE0001);
    chk("free_arid", 32'(arid), 32'd1);
    chk("free_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("free_inst_rdata", inst_rdata, 32'hC0DE0001);
    chk("send_no_grant", 32'(inst_addr_ok), 32'd0);
    drive(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
    chk("refill_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
    chk("refill_araddr", araddr, 32'h2000);
    // drain four inst and one data response, no error expected
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 32'hD0 + 32'(k));
      chk($sformatf("drain%0d_inst_data_ok", k), 32'(inst_data_ok), 32'd1);
      chk($sformatf("drain%0d_inst_rdata", k), inst_rdata, 32'hD0 + 32'(k));
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd1, 32'hE0);
    chk("drain_data_data_ok", 32'(data_data_ok), 32'd1);
    idle_cycle();
    chk("drained_busy", 32'(busy), 32'd0);
    chk("drained_err", 32'(err_unexp), 32'd0);

    // unexpected data beat: still delivered, error becomes sticky
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd1, 32'hDEADBEEF);
    chk("unexp_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("unexp_data_rdata", data_rdata, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      idle_cycle();
      chk($sformatf("sticky%0d_err", k), 32'(err_unexp), 32'd1);
      chk($sformatf("sticky%0d_busy", k), 32'(busy), 32'd0);
    end

    // reset while an AR is waiting for arready
    drive(1'b1, 32'h4000, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("midrst_grant", 32'(inst_addr_ok), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("midrst_arvalid_before", 32'(arvalid), 32'd1);
    @(negedge clk);
    resetn = 1'b0; rvalid = 1'b1; rid = 4'd0;
    #2;
    chk("midrst_arvalid_in_rst", 32'(arvalid), 32'd0);
    chk("midrst_rready_in_rst", 32'(rready), 32'd0);
    chk("midrst_data_ok_in_rst", 32'(inst_data_ok), 32'd0);
    @(negedge clk);
    resetn = 1'b1; rvalid = 1'b0;
    #2;
    chk("midrst_arvalid_after", 32'(arvalid), 32'd0);
    chk("midrst_busy_after", 32'(busy), 32'd0);
    chk("midrst_err_after", 32'(err_unexp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
